uart_tx_interface: RTL and testbench

//  Serialises one parallel byte per request into an asynchronous UART frame: 1 start bit (0),

---
 rtl/uart_tx_interface_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_tx_interface.sv | 143 ++++++++++++++
 tb/tb_uart_tx_interface.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_interface_pkg.sv
// ============================================================================
//  Module   : uart_tx_interface_pkg
//  Brief    : Shared UART timing derivation and TX/RX FSM state encodings.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_tx_interface_pkg;

    localparam int c_DIV_SAMPLE_DEFAULT = 16;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // Clocks per sub-tick; the receiver uses the same integer division so both ends agree.
    function automatic int div_counter(input int clk_freq, input int baud_rate, input int div_sample);
        return clk_freq / (baud_rate * div_sample);
    endfunction

    function automatic int bit_clks(input int clk_freq, input int baud_rate, input int div_sample);
        return div_counter(clk_freq, baud_rate, div_sample) * div_sample;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
//  Module   : uart_baud_tick
//  Brief    : Free-running 0..DIV_COUNTER-1 counter emitting a 1-cycle tick.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int DIV_COUNTER = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                 c_CNT_W = $clog2(DIV_COUNTER + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV_COUNTER - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_interface.sv
// ============================================================================
//  Module   : uart_tx_interface
//  Brief    : UART transmitter, 1 start, DATA_BITS LSB-first, STOP_BITS stop.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_interface
    import uart_tx_interface_pkg::*;
#(
    parameter int CLK_FREQ   = 5000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DIV_SAMPLE = c_DIV_SAMPLE_DEFAULT,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_uart_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);

    localparam int c_DIV_COUNTER = div_counter(CLK_FREQ, BAUD_RATE, DIV_SAMPLE);
    localparam int c_SUB_W       = $clog2(DIV_SAMPLE + 1);
    localparam int c_BIT_W       = $clog2(DATA_BITS + STOP_BITS + 1);

    localparam logic [c_SUB_W-1:0] c_SUB_LAST  = c_SUB_W'(DIV_SAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

    generate
        if (c_DIV_COUNTER < 1) begin : g_bad_div
            $error("uart_tx_interface: CLK_FREQ too low for BAUD_RATE*DIV_SAMPLE");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_interface: STOP_BITS must be 1 or 2");
        end
    endgenerate

    logic [1:0]           r_state;
    logic [c_SUB_W-1:0]   r_sub;
    logic [c_BIT_W-1:0]   r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;

    logic w_tick;
    logic w_baud_clr;
    logic w_bit_end;

    // Holding the divider clear while idle aligns every bit edge to the accept edge.
    assign w_baud_clr = (r_state == c_ST_IDLE);
    assign w_bit_end  = w_tick && (r_sub == c_SUB_LAST);

    uart_baud_tick #(
        .DIV_COUNTER (c_DIV_COUNTER)
    ) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_baud_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset || (r_state == c_ST_IDLE)) begin
            r_sub <= '0;
        end else if (w_tick) begin
            r_sub <= (r_sub == c_SUB_LAST) ? '0 : r_sub + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_bit <= '0;
                    if (i_tx_start) begin
                        r_state <= c_ST_START;
                        r_shift <= i_tx_data;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_state <= c_ST_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == c_DATA_LAST) begin
                            r_state <= c_ST_STOP;
                            r_tx    <= 1'b1;
                            r_bit   <= '0;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit == c_STOP_LAST) begin
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_bit   <= '0;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_uart_tx = r_tx;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_interface.sv
// ============================================================================
//  Module   : tb_uart_tx_interface
//  Brief    : Directed self-checking bench for uart_tx_interface.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_interface;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_tx_start;
    logic [7:0] i_tx_data;
    logic       o_uart_tx;
    logic       o_tx_busy;
    logic       o_tx_done;

    logic       lb_start;
    logic [7:0] lb_data;
    logic       lb_tx;
    logic       lb_busy;
    logic       lb_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int last_done = 0;

    always #5 clk = ~clk;

    uart_tx_interface u_dut (
        .clk        (clk),
        .reset      (reset),
        .i_tx_start (i_tx_start),
        .i_tx_data  (i_tx_data),
        .o_uart_tx  (o_uart_tx),
        .o_tx_busy  (o_tx_busy),
        .o_tx_done  (o_tx_done)
    );

    // 307200 Hz / (9600*16) = 2 clocks per sub-tick, 32 per bit, 352 per 8N2 frame
    uart_tx_interface #(
        .CLK_FREQ  (307200),
        .STOP_BITS (2)
    ) u_lb (
        .clk        (clk),
        .reset      (reset),
        .i_tx_start (lb_start),
        .i_tx_data  (lb_data),
        .o_uart_tx  (lb_tx),
        .o_tx_busy  (lb_busy),
        .o_tx_done  (lb_done)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_tx_busy) busy_cnt <= busy_cnt + 1;
        if (o_tx_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // expb[n] is the line value at accept+256+n*512
    task automatic frame(input string tag, input logic [7:0] d, input logic [9:0] expb,
                         input bit poke, input bit chained);
        int k, b0;
        i_tx_start = 1'b1;
        i_tx_data  = d;
        @(negedge clk);
        i_tx_start = 1'b0;
        i_tx_data  = ~d;
        k  = cyc;
        b0 = busy_cnt;
        if (chained) chk({tag, " gap"}, k - last_done, 1);
        chk({tag, " start_tx"}, o_uart_tx, 0);
        chk({tag, " start_busy"}, o_tx_busy, 1);
        adv(256);
        for (int n = 0; n < 10; n++) begin
            chk($sformatf("%s bit%0d", tag, n), o_uart_tx, expb[n]);
            if (n < 9) begin
                if (poke && n == 4) begin
                    i_tx_start = 1'b1;
                    i_tx_data  = 8'hFF;
                    adv(1);
                    i_tx_start = 1'b0;
                    adv(511);
                end else begin
                    adv(512);
                end
            end
        end
        adv(255);
        chk({tag, " done_early"}, o_tx_done, 0);
        chk({tag, " busy_late"}, o_tx_busy, 1);
        adv(1);
        chk({tag, " done"}, o_tx_done, 1);
        chk({tag, " busy_end"}, o_tx_busy, 0);
        chk({tag, " idle_tx"}, o_uart_tx, 1);
        chk({tag, " busy_len"}, busy_cnt - b0, 5120);
        chk({tag, " frame_len"}, cyc - k, 5120);
        last_done = cyc;
    endtask

    initial begin
        int d0, k, t;
        logic [10:0] rx;
        logic [7:0]  rb;

        reset      = 1'b1;
        i_tx_start = 1'b1;
        i_tx_data  = 8'hA5;
        lb_start   = 1'b0;
        lb_data    = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", o_uart_tx, 1);
            chk("rst_busy", o_tx_busy, 0);
            chk("rst_done", o_tx_done, 0);
        end
        reset      = 1'b0;
        i_tx_start = 1'b0;
        adv(5);
        chk("post_rst_busy", o_tx_busy, 0);
        chk("post_rst_tx", o_uart_tx, 1);

        frame("f55", 8'h55, 10'b1010101010, 1'b0, 1'b0);
        adv(3);

        frame("fA3", 8'hA3, 10'b1101000110, 1'b0, 1'b0);
        frame("f0F", 8'h0F, 10'b1000011110, 1'b0, 1'b1);
        adv(3);

        d0 = done_cnt;
        frame("f00", 8'h00, 10'b1000000000, 1'b1, 1'b0);
        adv(20);
        chk("ignored_done_count", done_cnt - d0, 1);
        chk("ignored_not_queued", o_tx_busy, 0);

        i_tx_start = 1'b1;
        i_tx_data  = 8'h00;
        @(negedge clk);
        i_tx_start = 1'b0;
        adv(256 + 4 * 512);
        chk("mid_tx_low", o_uart_tx, 0);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", o_uart_tx, 1);
        chk("mid_rst_busy", o_tx_busy, 0);
        reset = 1'b0;
        adv(3200);
        chk("mid_rst_no_done", done_cnt - d0, 0);

        frame("f3C", 8'h3C, 10'b1001111000, 1'b0, 1'b0);
        adv(3);

        for (int i = 0; i < 32; i++) begin
            rb       = 8'($urandom);
            lb_start = 1'b1;
            lb_data  = rb;
            @(negedge clk);
            lb_start = 1'b0;
            lb_data  = ~rb;
            k = cyc;
            adv(16);
            for (int n = 0; n < 11; n++) begin
                rx[n] = lb_tx;
                if (n < 10) adv(32);
            end
            t = 0;
            while (!lb_done && t < 400) begin
                adv(1);
                t++;
            end
            chk($sformatf("lb%0d data", i), {21'd0, rx}, {21'd0, 2'b11, rb, 1'b0});
            chk($sformatf("lb%0d len", i), cyc - k, 352);
            adv(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
